// File: rtl/muldiv_pkg.sv
// Shared types and opcode decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [3:0] {
      MD_MUL    = 4'h0, MD_MULH  = 4'h1, MD_MULHSU = 4'h2, MD_MULHU = 4'h3,
      MD_DIV    = 4'h4, MD_DIVU  = 4'h5, MD_REM    = 4'h6, MD_REMU  = 4'h7,
      MD_MULW   = 4'h8, MD_DIVW  = 4'hC, MD_DIVUW  = 4'hD, MD_REMW  = 4'hE,
      MD_REMUW  = 4'hF
   } md_op_t;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;

   function automatic logic is_div(input md_op_t op);
      logic [3:0] v;
      v = op;
      return v[2];
   endfunction

   function automatic logic is_rem(input md_op_t op);
      logic [3:0] v;
      v = op;
      return v[2] & v[1];
   endfunction

   function automatic logic is_high(input md_op_t op);
      logic [3:0] v;
      v = op;
      return ~v[2] & (v[1] | v[0]);
   endfunction

   // MULH, MULHSU, DIV, REM (and the W-forms of DIV/REM)
   function automatic logic is_signed_a(input md_op_t op);
      logic [3:0] v;
      v = op;
      return (v[2:0] == 3'd1) || (v[2:0] == 3'd2) || (v[2:0] == 3'd4) || (v[2:0] == 3'd6);
   endfunction

   function automatic logic is_signed_b(input md_op_t op);
      logic [3:0] v;
      v = op;
      return (v[2:0] == 3'd1) || (v[2:0] == 3'd4) || (v[2:0] == 3'd6);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: MSB-first shift-add multiply or restoring divide.
module muldiv_step #(
   parameter int XLEN = 64
) (
   input  logic                div,
   input  logic [2*XLEN-1:0]   acc,
   input  logic [XLEN-1:0]     shreg,
   input  logic [XLEN-1:0]     operand,
   output logic [2*XLEN-1:0]   acc_next,
   output logic [XLEN-1:0]     shreg_next
);

   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;

   // The partial remainder never exceeds the divisor, so XLEN+1 bits suffice.
   assign rem_sh = {acc[XLEN-1:0], shreg[XLEN-1]};
   assign diff   = {1'b0, rem_sh} - {2'b00, operand};

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      acc_next   = '0;
      shreg_next = {shreg[XLEN-2:0], 1'b0};
      if (div) begin
         if (!diff[XLEN+1]) begin
            acc_next      = {{(XLEN-1){1'b0}}, diff[XLEN:0]};
            shreg_next[0] = 1'b1;
         end else begin
            acc_next = {{(XLEN-1){1'b0}}, rem_sh};
         end
      end else begin
         acc_next = {acc[2*XLEN-2:0], 1'b0}
                  + {{XLEN{1'b0}}, operand & {XLEN{shreg[XLEN-1]}}};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshake and tag.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  md_op_t           in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] LOW_MASK = {XLEN{1'b1}} >> (XLEN - 32);

   function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w);
      return w ? XLEN'($signed(v[31:0])) : v;
   endfunction

   md_state_t         state_q, state_d;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc, acc_nx;
   logic [XLEN-1:0]   shreg, sh_nx, operand;
   logic              div_q, rem_q, high_q, word_q, neg_q, sign_a_q;

   // Accept-time decode
   logic            accept, word_in, a_neg, b_neg, div0, ovf, special;
   logic [XLEN-1:0] mask, a_n, b_n, abs_a, abs_b, min_n, spec_res;

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid & in_ready & ~flush;
   assign word_in  = (XLEN == 64) && in_op[3];
   assign mask     = word_in ? LOW_MASK : '1;
   assign min_n    = word_in ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
   assign a_n      = in_a & mask;
   assign b_n      = in_b & mask;
   assign a_neg    = is_signed_a(in_op) & (word_in ? in_a[31] : in_a[XLEN-1]);
   assign b_neg    = is_signed_b(in_op) & (word_in ? in_b[31] : in_b[XLEN-1]);
   assign abs_a    = a_neg ? ((~a_n + 1'b1) & mask) : a_n;
   assign abs_b    = b_neg ? ((~b_n + 1'b1) & mask) : b_n;
   assign div0     = (b_n == '0);
   assign ovf      = is_signed_a(in_op) && (a_n == min_n) && (b_n == mask);
   assign special  = is_div(in_op) & (div0 | ovf);
   assign spec_res = fit(div0 ? (is_rem(in_op) ? a_n : '1) : (is_rem(in_op) ? '0 : a_n), word_in);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .div        (div_q),
      .acc        (acc),
      .shreg      (shreg),
      .operand    (operand),
      .acc_next   (acc_nx),
      .shreg_next (sh_nx)
   );

   // Sign correction and result selection happen alongside the final step.
   logic              last;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res, div_res, final_res;

   assign last      = (cnt == (word_q ? CW'(31) : CW'(XLEN - 1)));
   assign prod      = neg_q ? (~acc_nx + 1'b1) : acc_nx;
   assign mul_res   = high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   assign div_res   = rem_q ? (sign_a_q ? (~acc_nx[XLEN-1:0] + 1'b1) : acc_nx[XLEN-1:0])
                            : (neg_q ? (~sh_nx + 1'b1) : sh_nx);
   assign final_res = fit(div_q ? div_res : mul_res, word_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = special ? DONE : BUSY;
         BUSY:    if (last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= (state_d == DONE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         acc        <= '0;
         shreg      <= '0;
         operand    <= '0;
         div_q      <= 1'b0;
         rem_q      <= 1'b0;
         high_q     <= 1'b0;
         word_q     <= 1'b0;
         neg_q      <= 1'b0;
         sign_a_q   <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else if (accept) begin
         cnt      <= '0;
         acc      <= '0;
         div_q    <= is_div(in_op);
         rem_q    <= is_rem(in_op);
         high_q   <= is_high(in_op);
         word_q   <= word_in;
         neg_q    <= a_neg ^ b_neg;
         sign_a_q <= a_neg;
         out_tag  <= in_tag;
         // Multiplier (or dividend) is top-aligned so both widths consume it MSB-first.
         if (is_div(in_op)) begin
            shreg   <= word_in ? (abs_a << 32) : abs_a;
            operand <= abs_b;
         end else begin
            shreg   <= word_in ? (abs_b << 32) : abs_b;
            operand <= abs_a;
         end
         if (special) out_result <= spec_res;
      end else if (state_q == BUSY && !flush) begin
         cnt   <= cnt + 1'b1;
         acc   <= acc_nx;
         shreg <= sh_nx;
         if (last) out_result <= final_res;
      end
   end

endmodule
